// File: rtl/seq_match_monitor.sv
// seq_match_monitor: watches the IF/D and/or EXEC instruction stream, keeps a
// sliding history of accepted opcodes and matches it against NUM_SEQ
// independently programmable opcode sequences. Each channel pulses a hit and
// keeps a saturating hit counter readable through a registered read port.
//
// Source selection (MODE):
//   0 = accept when IF/D and EXEC are both valid (EXEC opcode is recorded,
//       IF/D vs EXEC disagreements are counted)
//   1 = accept on IF/D valid only
//   2 = accept on EXEC valid only
//   other = monitor disabled (only configuration storage is live)
//
// Optional feature macro: SEQ_MATCH_WILDCARD_EN
//   When defined, a sequence element of all-ones matches any accepted opcode.
//   When undefined, all-ones is an ordinary opcode compared exactly.

module seq_match_monitor #(
    parameter int OP_W    = 8,
    parameter int MAX_LEN = 8,
    parameter int NUM_SEQ = 4,
    parameter int CNT_W   = 16,
    parameter int MODE    = 0,
    localparam int SEQ_W  = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1,
    localparam int IDX_W  = $clog2(MAX_LEN),
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ifd_valid,
    input  logic [OP_W-1:0]    ifd_op,
    input  logic               exec_valid,
    input  logic [OP_W-1:0]    exec_op,
    input  logic               clear,
    input  logic               cfg_we,
    input  logic [SEQ_W-1:0]   cfg_seq,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [OP_W-1:0]    cfg_op,
    input  logic               cfg_len_we,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [SEQ_W-1:0]   rd_seq,
    output logic [CNT_W-1:0]   rd_count,
    output logic [NUM_SEQ-1:0] hit,
    output logic [CNT_W-1:0]   mismatch_cnt
);

    typedef logic [OP_W-1:0] op_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    // Configuration storage: sequence elements (index 0 = oldest) and lengths
    op_t              seq_q [NUM_SEQ][MAX_LEN];
    op_t              seq_d [NUM_SEQ][MAX_LEN];
    logic [LEN_W-1:0] len_q [NUM_SEQ];
    logic [LEN_W-1:0] len_d [NUM_SEQ];

    // Opcode history, newest at index 0, and how many entries are valid
    op_t              hist_q [MAX_LEN];
    op_t              hist_d [MAX_LEN];
    logic [LEN_W-1:0] fill_q;
    logic [LEN_W-1:0] fill_d;

    // Per-channel counters, hit pulses and the read/mismatch registers
    logic [CNT_W-1:0]   cnt_q [NUM_SEQ];
    logic [CNT_W-1:0]   cnt_d [NUM_SEQ];
    logic [NUM_SEQ-1:0] hit_q;
    logic [NUM_SEQ-1:0] hit_d;
    logic [CNT_W-1:0]   rd_count_q;
    logic [CNT_W-1:0]   rd_count_d;
    logic [CNT_W-1:0]   mismatch_q;
    logic [CNT_W-1:0]   mismatch_d;

    // Post-shift view of the history, used both for matching and as next state
    op_t              histShift [MAX_LEN];
    logic [LEN_W-1:0] fillShift;
    logic [NUM_SEQ-1:0] matchVec;

    // Accept strobe, accepted opcode and IF/D vs EXEC disagreement
    logic acc;
    op_t  accOp;
    logic disagree;

    // Element comparison, optionally treating all-ones as "don't care"
    function automatic logic elemMatch(input op_t expected, input op_t observed);
`ifdef SEQ_MATCH_WILDCARD_EN
        return (expected == '1) || (expected == observed);
`else
        return expected == observed;
`endif
    endfunction

    // Source select is fixed at elaboration time by MODE
    generate
        if (MODE == 0) begin : gSrcBoth
            assign acc      = ifd_valid & exec_valid;
            assign accOp    = exec_op;
            assign disagree = (ifd_op != exec_op);
        end else if (MODE == 1) begin : gSrcIfd
            wire unusedInputs = ^{exec_valid, exec_op};
            assign acc      = ifd_valid;
            assign accOp    = ifd_op;
            assign disagree = 1'b0;
        end else if (MODE == 2) begin : gSrcExec
            wire unusedInputs = ^{ifd_valid, ifd_op};
            assign acc      = exec_valid;
            assign accOp    = exec_op;
            assign disagree = 1'b0;
        end else begin : gSrcOff
            wire unusedInputs = ^{ifd_valid, ifd_op, exec_valid, exec_op};
            assign acc      = 1'b0;
            assign accOp    = '0;
            assign disagree = 1'b0;
        end
    endgenerate

    // Configuration writes; out-of-range channel or index writes are dropped
    always_comb begin
        seq_d = seq_q;
        len_d = len_q;
        if (cfg_we && (int'(cfg_seq) < NUM_SEQ) && (int'(cfg_idx) < MAX_LEN)) begin
            seq_d[cfg_seq][cfg_idx] = cfg_op;
        end
        if (cfg_len_we && (int'(cfg_seq) < NUM_SEQ)) begin
            len_d[cfg_seq] = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        end
    end

    // Shift the accepted opcode into the history and advance the fill level
    always_comb begin
        histShift = hist_q;
        fillShift = fill_q;
        if (acc) begin
            histShift[0] = accOp;
            for (int i = 1; i < MAX_LEN; i++) begin
                histShift[i] = hist_q[i-1];
            end
            if (fill_q != LEN_MAX) begin
                fillShift = fill_q + LEN_W'(1);
            end
        end
    end

    // Compare each channel's sequence against the post-shift history window
    always_comb begin
        matchVec = '0;
        for (int s = 0; s < NUM_SEQ; s++) begin
            matchVec[s] = acc && (len_q[s] != '0) && (fillShift >= len_q[s]);
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < int'(len_q[s])) begin
                    if (!elemMatch(seq_q[s][i],
                                   histShift[IDX_W'(int'(len_q[s]) - 1 - i)])) begin
                        matchVec[s] = 1'b0;
                    end
                end
            end
        end
    end

    // Hit pulses, saturating counters, mismatch count, read port and clear
    always_comb begin
        hit_d      = matchVec;
        cnt_d      = cnt_q;
        hist_d     = histShift;
        fill_d     = fillShift;
        mismatch_d = mismatch_q;
        rd_count_d = '0;

        for (int s = 0; s < NUM_SEQ; s++) begin
            if (matchVec[s] && (cnt_q[s] != CNT_MAX)) begin
                cnt_d[s] = cnt_q[s] + CNT_W'(1);
            end
        end

        if (acc && disagree && (mismatch_q != CNT_MAX)) begin
            mismatch_d = mismatch_q + CNT_W'(1);
        end

        if (int'(rd_seq) < NUM_SEQ) begin
            rd_count_d = cnt_q[rd_seq];
        end

        if (clear) begin
            hit_d      = '0;
            mismatch_d = '0;
            fill_d     = '0;
            for (int s = 0; s < NUM_SEQ; s++) begin
                cnt_d[s] = '0;
            end
            for (int i = 0; i < MAX_LEN; i++) begin
                hist_d[i] = '0;
            end
        end
    end

    // State registers; reset clears everything including configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q     <= '0;
            hit_q      <= '0;
            rd_count_q <= '0;
            mismatch_q <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                hist_q[i] <= '0;
            end
            for (int s = 0; s < NUM_SEQ; s++) begin
                cnt_q[s] <= '0;
                len_q[s] <= '0;
                for (int i = 0; i < MAX_LEN; i++) begin
                    seq_q[s][i] <= '0;
                end
            end
        end else begin
            fill_q     <= fill_d;
            hit_q      <= hit_d;
            rd_count_q <= rd_count_d;
            mismatch_q <= mismatch_d;
            hist_q     <= hist_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            seq_q      <= seq_d;
        end
    end

    assign rd_count     = rd_count_q;
    assign hit          = hit_q;
    assign mismatch_cnt = mismatch_q;

endmodule

// File: tb/tb_seq_match_monitor.sv
// Directed testbench for seq_match_monitor. Four instances share one set of
// stimulus: A (EXEC only), B (IF/D and EXEC), C (EXEC only, 4-bit counters)
// and D (disabled). Expected values are hand-computed constants.
// Optional feature macro honoured: SEQ_MATCH_WILDCARD_EN

module tb_seq_match_monitor;

    logic       clk;
    logic       rst;
    logic       ifdValid;
    logic [7:0] ifdOp;
    logic       execValid;
    logic [7:0] execOp;
    logic       clear;
    logic       cfgWe;
    logic [1:0] cfgSeq;
    logic [2:0] cfgIdx;
    logic [7:0] cfgOp;
    logic       cfgLenWe;
    logic [3:0] cfgLen;
    logic [1:0] rdSeq;

    logic [15:0] rdCountA, mmA, rdCountB, mmB, rdCountD, mmD;
    logic [3:0]  hitA, hitB, hitC, hitD;
    logic [3:0]  rdCountC, mmC;

    int testsRun  = 0;
    int failCount = 0;

    seq_match_monitor #(.MODE(2)) dutA (
        .clk(clk), .rst(rst), .ifd_valid(ifdValid), .ifd_op(ifdOp),
        .exec_valid(execValid), .exec_op(execOp), .clear(clear),
        .cfg_we(cfgWe), .cfg_seq(cfgSeq), .cfg_idx(cfgIdx), .cfg_op(cfgOp),
        .cfg_len_we(cfgLenWe), .cfg_len(cfgLen), .rd_seq(rdSeq),
        .rd_count(rdCountA), .hit(hitA), .mismatch_cnt(mmA)
    );

    seq_match_monitor #(.MODE(0)) dutB (
        .clk(clk), .rst(rst), .ifd_valid(ifdValid), .ifd_op(ifdOp),
        .exec_valid(execValid), .exec_op(execOp), .clear(clear),
        .cfg_we(cfgWe), .cfg_seq(cfgSeq), .cfg_idx(cfgIdx), .cfg_op(cfgOp),
        .cfg_len_we(cfgLenWe), .cfg_len(cfgLen), .rd_seq(rdSeq),
        .rd_count(rdCountB), .hit(hitB), .mismatch_cnt(mmB)
    );

    seq_match_monitor #(.MODE(2), .CNT_W(4)) dutC (
        .clk(clk), .rst(rst), .ifd_valid(ifdValid), .ifd_op(ifdOp),
        .exec_valid(execValid), .exec_op(execOp), .clear(clear),
        .cfg_we(cfgWe), .cfg_seq(cfgSeq), .cfg_idx(cfgIdx), .cfg_op(cfgOp),
        .cfg_len_we(cfgLenWe), .cfg_len(cfgLen), .rd_seq(rdSeq),
        .rd_count(rdCountC), .hit(hitC), .mismatch_cnt(mmC)
    );

    seq_match_monitor #(.MODE(3)) dutD (
        .clk(clk), .rst(rst), .ifd_valid(ifdValid), .ifd_op(ifdOp),
        .exec_valid(execValid), .exec_op(execOp), .clear(clear),
        .cfg_we(cfgWe), .cfg_seq(cfgSeq), .cfg_idx(cfgIdx), .cfg_op(cfgOp),
        .cfg_len_we(cfgLenWe), .cfg_len(cfgLen), .rd_seq(rdSeq),
        .rd_count(rdCountD), .hit(hitD), .mismatch_cnt(mmD)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with the given observation strobes, then strobes drop
    task automatic applyStimulus(input logic iv, input logic [7:0] io,
                                 input logic ev, input logic [7:0] eo);
        ifdValid  = iv;
        ifdOp     = io;
        execValid = ev;
        execOp    = eo;
        tick();
        ifdValid  = 1'b0;
        execValid = 1'b0;
    endtask

    task automatic cfgElem(input logic [1:0] s, input logic [2:0] i, input logic [7:0] o);
        cfgWe  = 1'b1;
        cfgSeq = s;
        cfgIdx = i;
        cfgOp  = o;
        tick();
        cfgWe  = 1'b0;
    endtask

    task automatic cfgLength(input logic [1:0] s, input logic [3:0] l);
        cfgLenWe = 1'b1;
        cfgSeq   = s;
        cfgLen   = l;
        tick();
        cfgLenWe = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] seqOps  [6] = '{8'h01, 8'h02, 8'h02, 8'h03, 8'h0F, 8'h05};
        logic [3:0] seqHits [6] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
        logic [3:0] expWild;

        rst = 1'b1; clear = 1'b0;
        ifdValid = 1'b0; ifdOp = '0; execValid = 1'b0; execOp = '0;
        cfgWe = 1'b0; cfgSeq = '0; cfgIdx = '0; cfgOp = '0;
        cfgLenWe = 1'b0; cfgLen = '0; rdSeq = '0;
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_hitA", 32'(hitA), 32'h0);
        checkOutput("reset_rdA", 32'(rdCountA), 32'h0);
        checkOutput("reset_mmB", 32'(mmB), 32'h0);
        checkOutput("reset_rdC", 32'(rdCountC), 32'h0);

        $display("[TB] six-element sequence on ch0, pair on ch1");
        for (int i = 0; i < 6; i++) cfgElem(2'd0, 3'(i), seqOps[i]);
        cfgLength(2'd0, 4'd6);
        cfgElem(2'd1, 3'd0, 8'h02);
        cfgElem(2'd1, 3'd1, 8'h02);
        cfgLength(2'd1, 4'd2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, seqOps[i]);
            checkOutput($sformatf("seq6_hitA_ev%0d", i), 32'(hitA), 32'(seqHits[i]));
        end
        tick();
        checkOutput("seq6_hit_drops", 32'(hitA), 32'h0);
        checkOutput("seq6_rd_ch0", 32'(rdCountA), 32'd1);
        rdSeq = 2'd1;
        tick();
        checkOutput("seq6_rd_ch1", 32'(rdCountA), 32'd1);

        $display("[TB] overlapping pair matches");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h02);
        checkOutput("ovl_ev0", 32'(hitA), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h02);
        checkOutput("ovl_ev1", 32'(hitA), 32'h2);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h02);
        checkOutput("ovl_ev2", 32'(hitA), 32'h2);
        tick();
        checkOutput("ovl_cnt1", 32'(rdCountA), 32'd2);

        $display("[TB] dual-source mode and mismatch counting");
        applyStimulus(1'b1, 8'h01, 1'b1, 8'h01);
        checkOutput("mm_agree", 32'(mmB), 32'd0);
        applyStimulus(1'b1, 8'h03, 1'b1, 8'h04);
        checkOutput("mm_disagree", 32'(mmB), 32'd1);
        applyStimulus(1'b1, 8'h02, 1'b0, 8'h00);
        checkOutput("ifd_only_hitB0", 32'(hitB), 32'h0);
        applyStimulus(1'b1, 8'h02, 1'b0, 8'h00);
        checkOutput("ifd_only_hitB1", 32'(hitB), 32'h0);
        applyStimulus(1'b1, 8'h02, 1'b1, 8'h02);
        checkOutput("both_hitB_first", 32'(hitB), 32'h0);
        applyStimulus(1'b1, 8'h02, 1'b1, 8'h02);
        checkOutput("both_hitB_second", 32'(hitB), 32'h2);
        checkOutput("mm_hold", 32'(mmB), 32'd1);

        $display("[TB] counter saturation and clear");
        cfgElem(2'd0, 3'd0, 8'h07);
        cfgLength(2'd0, 4'd1);
        rdSeq = 2'd0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clear_mmB", 32'(mmB), 32'd0);
        for (int n = 0; n < 20; n++) applyStimulus(1'b0, 8'h00, 1'b1, 8'h07);
        checkOutput("sat_hitC", 32'(hitC), 32'h1);
        tick();
        checkOutput("sat_rdC", 32'(rdCountC), 32'd15);
        checkOutput("nosat_rdA", 32'(rdCountA), 32'd20);
        clear = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h07);
        clear = 1'b0;
        checkOutput("clear_acc_hitC", 32'(hitC), 32'h0);
        tick();
        checkOutput("clear_rdC", 32'(rdCountC), 32'd0);

        $display("[TB] reset mid-sequence, fill guard, disabled channel");
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h02);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_rdA", 32'(rdCountA), 32'd0);
        cfgLength(2'd3, 4'd2);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h00);
        checkOutput("fill_guard_ev0", 32'(hitA), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h00);
        checkOutput("fill_guard_ev1", 32'(hitA), 32'h8);
        for (int i = 0; i < 6; i++) cfgElem(2'd0, 3'(i), seqOps[i]);
        cfgLength(2'd0, 4'd6);
        for (int i = 3; i < 6; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, seqOps[i]);
            checkOutput($sformatf("midrst_ev%0d", i), 32'(hitA), 32'h0);
        end
        cfgLength(2'd0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, seqOps[i]);
            checkOutput($sformatf("len0_ev%0d", i), 32'(hitA), 32'h0);
        end

        $display("[TB] all-ones sequence element");
        cfgElem(2'd2, 3'd0, 8'h01);
        cfgElem(2'd2, 3'd1, 8'hFF);
        cfgElem(2'd2, 3'd2, 8'h05);
        cfgLength(2'd2, 4'd3);
`ifdef SEQ_MATCH_WILDCARD_EN
        expWild = 4'b0100;
`else
        expWild = 4'b0000;
`endif
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h3A);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h05);
        checkOutput("wild_3A", 32'(hitA), 32'(expWild));
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hFF);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h05);
        checkOutput("wild_exact_FF", 32'(hitA), 32'h4);

        $display("[TB] disabled monitor");
        applyStimulus(1'b1, 8'h11, 1'b1, 8'h22);
        checkOutput("dis_mmB_live", 32'(mmB), 32'd1);
        checkOutput("dis_mmD", 32'(mmD), 32'd0);
        checkOutput("dis_hitD", 32'(hitD), 32'h0);
        tick();
        checkOutput("dis_rdD", 32'(rdCountD), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
